// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage with valid/ready handshakes on both sides.
// Shifts run serially, one bit per cycle, unless ALU_FAST_SHIFT_EN is defined (then a 1-cycle barrel shift).
module alu_exec_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [4:0]            rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic [4:0]            rd_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_e;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST_SHIFT = 1'b1;
`else
  localparam bit FAST_SHIFT = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic [4:0]            rd_q, rd_d;
  logic                  shift_left_q, shift_left_d;

  alu_op_e               op;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  slt_bit;
  logic                  is_serial_shift;
  logic                  in_fire;

  assign op      = alu_op_e'(alu_control);
  assign shamt   = src_b[SHAMT_W-1:0];
  assign slt_bit = $signed(src_a) < $signed(src_b);

  assign is_serial_shift = !FAST_SHIFT && ((op == OP_SLL) || (op == OP_SRL));

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign in_fire   = in_valid && in_ready;

  // Single-cycle result for every op; shift lanes only matter in the fast build.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
      OP_SLL:  alu_res = FAST_SHIFT ? (src_a << shamt) : src_a;
      OP_SRL:  alu_res = FAST_SHIFT ? (src_a >> shamt) : src_a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    shift_left_d = shift_left_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (in_fire) begin
          rd_d = rd_in;
          if (is_serial_shift) begin
            // result_q doubles as the shift working register while out_valid is low.
            state_d      = S_SHIFT;
            result_d     = src_a;
            cnt_d        = shamt;
            shift_left_d = (op == OP_SLL);
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        // A zero shift amount still spends exactly one cycle here, unshifted.
        if (cnt_q != '0) begin
          result_d = shift_left_q ? (result_q << 1) : (result_q >> 1);
          cnt_d    = cnt_q - SHAMT_W'(1);
        end
        if (cnt_q <= SHAMT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: zero is decoded from result, so clearing result on reset also yields zero=1 with no extra flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      result_q     <= '0;
      cnt_q        <= '0;
      rd_q         <= '0;
      shift_left_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      shift_left_q <= shift_left_d;
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);
  assign rd_out = rd_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: driver pushes expected results, negedge monitor pops and compares.
module tb_alu_exec_stage;

  localparam int DW = 32;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;

  typedef struct {
    logic [DW-1:0] res;
    logic [4:0]    rd;
    int            lat;
    int            issue_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_control;
  logic [DW-1:0] src_a, src_b;
  logic [4:0]    rd_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          zero;
  logic [4:0]    rd_out;

  alu_exec_stage #(.DATA_WIDTH(DW), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .rd_in      (rd_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .rd_out     (rd_out)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  logic force_rdy = 1'b1;
  logic rdy_val   = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the architectural result of each op, shifts as one plain shift.
  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    int unsigned sh = b[4:0];
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      SLT:     return ($signed(a) < $signed(b)) ? 1 : 0;
      SLL:     return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  // Cycles from the in-transfer cycle until out_valid is first seen.
  function automatic int ref_lat(input logic [2:0] op, input logic [DW-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    int sh = int'(b[4:0]);
    if (op == SLL || op == SRL) return ((sh == 0) ? 1 : sh) + 1;
    return 1;
`endif
  endfunction

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [4:0] rd);
    exp_t e;
    int   waited = 0;
    bit   ok = 1'b0;
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; rd_in = rd;
    while (waited < 200) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      waited++;
      @(posedge clk); #1;
    end
    if (ok) begin
      e.res = ref_alu(op, a, b); e.rd = rd; e.lat = ref_lat(op, b); e.issue_cyc = cyc;
      sb.push_back(e);
    end else begin
      check("issue_timeout", 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_control = 3'($urandom()); src_a = $urandom(); src_b = $urandom(); rd_in = 5'($urandom());
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      out_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  exp_t          mon_e;
  bit            head_seen = 1'b0;
  bit            held = 1'b0;
  logic [DW-1:0] held_res;
  logic [4:0]    held_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); head_seen = 1'b0; held = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        mon_e = sb[0];
        if (!head_seen) begin
          check("latency", 64'(cyc - mon_e.issue_cyc), 64'(mon_e.lat));
          head_seen = 1'b1;
        end
        if (held) begin
          check("hold_result", result, held_res);
          check("hold_rd_out", rd_out, held_rd);
        end
        if (out_ready) begin
          check("result", result, mon_e.res);
          check("zero", zero, mon_e.res == '0);
          check("rd_out", rd_out, mon_e.rd);
          void'(sb.pop_front());
          head_seen = 1'b0; held = 1'b0;
        end else begin
          held = 1'b1; held_res = result; held_rd = rd_out;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic saw_valid;
    logic [2:0] op;
    rst_n = 1'b0; in_valid = 1'b0; alu_control = '0; src_a = '0; src_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_zero", zero, 1'b1);
    check("rst_rd_out", rd_out, 5'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed corner cases with the consumer always ready.
    issue(ADD, 32'h7FFF_FFFF, 32'd1, 5'd3);
    issue(SUB, 32'd5, 32'd5, 5'd4);
    issue(SLT, 32'hFFFF_FFFF, 32'd1, 5'd5);
    issue(SRL, 32'h8000_0000, 32'd31, 5'd6);
    issue(SLL, 32'h0000_1234, 32'd0, 5'd7);
    issue(SLL, 32'h0000_0001, 32'd1, 5'd8);
    drain();

    // Backpressure: XOR result held while a new request is refused.
    rdy_val = 1'b0;
    issue(XOR_, 32'hA5A5_A5A5, 32'd0, 5'd9);
    in_valid = 1'b1; alu_control = ADD; src_a = 32'd1; src_b = 32'd2; rd_in = 5'd10;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_result", result, 32'hA5A5_A5A5);
      @(posedge clk); #1;
    end
    rdy_val = 1'b1;
    issue(ADD, 32'd1, 32'd2, 5'd10);
    drain();

    // Reset in the middle of a serial shift discards it.
    issue(SLL, 32'h0000_0001, 32'd10, 5'd11);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, '0);
    check("midrst_zero", zero, 1'b1);
    check("midrst_rd_out", rd_out, 5'd0);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b1);
    saw_valid = 1'b0;
    repeat (20) begin @(negedge clk); saw_valid |= out_valid; end
    check("midrst_no_output", saw_valid, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic with random consumer backpressure.
    force_rdy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op = 3'($urandom());
      issue(op, pick(), (op == SLL || op == SRL) ? 32'($urandom()) : pick(), 5'($urandom()));
    end
    force_rdy = 1'b1;
    rdy_val = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHAMT_W, default 5: shift-amount width; SHALL equal log2(DATA_WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  stage can accept a request this cycle.
REQ-007 alu_control  input  3  op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
REQ-008 src_a, src_b  input  DATA_WIDTH each  operands; shift amount is src_b[SHAMT_W-1:0].
REQ-009 rd_in  input  5  destination register tag, carried unchanged to rd_out.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  DATA_WIDTH  registered result.
REQ-013 zero  output  1  high when result is all zeros.
REQ-014 rd_out  output  5  tag of the operation in result.

Function
REQ-015 Transfer in SHALL occur when in_valid and in_ready are both high on a rising edge; transfer out when out_valid and out_ready are both high.
REQ-016 FSM states: IDLE, SHIFT, DONE; encoding is implementation choice.
REQ-017 IDLE: in_ready=1, out_valid=0; a non-shift op on transfer -> DONE with result registered; a shift op -> SHIFT with working register=src_a and counter=shamt.
REQ-018 SHIFT: in_ready=0, out_valid=0; each cycle shifts working register one bit (SLL left, SRL logical right, zero fill) and decrements counter; counter==0 -> DONE.
REQ-019 shamt==0 SHALL pass through SHIFT for exactly one cycle with result=src_a.
REQ-020 DONE: out_valid=1; result, zero and rd_out SHALL hold stable until out transfer.
REQ-021 DONE with out_ready=1: in_ready=1; simultaneous in transfer SHALL load the new op (non-shift -> DONE, shift -> SHIFT) with no bubble; without an in transfer -> IDLE.
REQ-022 DONE with out_ready=0: in_ready=0, state held.
REQ-023 Latency from in transfer to out_valid: 1 cycle for non-shift ops, shamt+1 cycles for shifts (serial mode).
REQ-024 ADD/SUB SHALL be modulo 2^DATA_WIDTH, carry discarded; SLT SHALL compare signed, result 1 or 0 zero-extended.
REQ-025 Inputs SHALL be sampled only on in transfer; changes at other times SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, out_valid=0, result=0, zero=1, rd_out=0, counter=0, independent of clk.
REQ-027 Reset asserted mid-shift or in DONE SHALL discard the operation; no result SHALL appear after release.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro ALU_FAST_SHIFT_EN defined: SLL/SRL SHALL complete as non-shift ops (1-cycle barrel shift, SHIFT state never entered).
REQ-030 Macro ALU_FAST_SHIFT_EN undefined: serial shift per REQ-018/019/023; all other behaviour identical.

Verification
REQ-031 ADD src_a=0x7FFFFFFF, src_b=1, rd_in=3 -> next cycle out_valid=1, result=0x80000000, zero=0, rd_out=3.
REQ-032 SUB 5-5 then back-to-back SLT 0xFFFFFFFF vs 1 with out_ready=1 -> results 0 (zero=1) then 1 on consecutive cycles, no bubble.
REQ-033 SRL src_a=0x80000000, shamt=31, serial -> out_valid after 32 cycles, result=0x00000001; with ALU_FAST_SHIFT_EN after 1 cycle.
REQ-034 XOR result 0xA5A5A5A5 held with out_ready=0 for 4 cycles -> result stable, in_ready=0; new in_valid ignored until out_ready=1.
REQ-035 SLL shamt=10 started, rst_n pulsed low at cycle 4 -> out_valid=0, result=0 immediately; no output after release; in_ready=1 next cycle.
REQ-036 SLL src_a=0x1234, shamt=0 -> result=0x1234 after 2 cycles (serial).
